// File: rtl/iq_rate_buffer_pkg.sv
// iq_rate_buffer_pkg: shared state encoding and default sizing for the IQ rate buffer
package iq_rate_buffer_pkg;
    localparam int DEF_DATA_W       = 12;
    localparam int DEF_ADDR_W       = 4;
    localparam int DEF_PRIME_LVL    = 8;
    localparam int DEF_OUT_INTERVAL = 4;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;
endpackage

// File: rtl/iq_rate_buffer_if.sv
// iq_rate_buffer_if: IQ sample stream in (from RX) and paced stream out (to TX)
interface iq_rate_buffer_if
    import iq_rate_buffer_pkg::*;
#(
    parameter int DW = DEF_DATA_W
);
    logic          i_iqdata_fp;
    logic [DW-1:0] i_idata;
    logic [DW-1:0] i_qdata;
    logic          o_iqdata_fp;
    logic [DW-1:0] o_idata;
    logic [DW-1:0] o_qdata;
    modport slave  (input i_iqdata_fp, i_idata, i_qdata, output o_iqdata_fp, o_idata, o_qdata);
    modport master (output i_iqdata_fp, i_idata, i_qdata, input o_iqdata_fp, o_idata, o_qdata);
endinterface

// File: rtl/iq_sync_fifo.sv
// iq_sync_fifo: single-clock FIFO with flush, occupancy count and full/empty flags
module iq_sync_fifo #(
    parameter int W      = 24,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [W-1:0]      i_wdata,
    output logic [W-1:0]      o_rdata,
    output logic [ADDR_W:0]   o_level,
    output logic              o_full,
    output logic              o_empty
);
    logic [W-1:0]      r_mem [2**ADDR_W];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              w_push;
    assign o_full  = r_level == (ADDR_W+1)'(2**ADDR_W);
    assign o_empty = r_level == '0;
    // a pop in the same cycle frees the slot a full FIFO would otherwise refuse
    assign w_push  = i_push & (~o_full | i_pop);
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_level = r_level;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(w_push);
            r_rd_ptr <= r_rd_ptr + ADDR_W'(i_pop);
            r_level  <= r_level + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(i_pop);
        end
    end
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end
endmodule

// File: rtl/iq_rate_buffer.sv
// iq_rate_buffer: absorbs RX strobe jitter and re-emits IQ pairs on a fixed output cadence
module iq_rate_buffer
    import iq_rate_buffer_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int PRIME_LVL    = DEF_PRIME_LVL,
    parameter int OUT_INTERVAL = DEF_OUT_INTERVAL
) (
    input  logic              i_fpga_clk,
    input  logic              i_fpga_rst,
    input  logic              i_enable,
    input  logic              i_clr_status,
    iq_rate_buffer_if.slave   io_iq,
    output logic [ADDR_W:0]   o_level,
    output logic              o_running,
    output logic              o_ovf,
    output logic              o_udf
);
    localparam int PACE_W = OUT_INTERVAL > 1 ? $clog2(OUT_INTERVAL) : 1;
    state_t              r_state;
    state_t              w_next;
    logic [PACE_W-1:0]   r_pace;
    logic [PACE_W-1:0]   w_pace_next;
    logic                r_running;
    logic                r_strobe;
    logic [DATA_W-1:0]   r_idata;
    logic [DATA_W-1:0]   r_qdata;
    logic                r_ovf;
    logic                r_udf;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_slot;
    logic                w_ovf_evt;
    logic                w_udf_evt;
    logic [2*DATA_W-1:0] w_rdata;
    logic [ADDR_W:0]     w_level;
    assign w_slot    = i_enable & (r_state == RUN) & (r_pace == '0);
    assign w_pop     = w_slot & ~w_empty;
    assign w_udf_evt = w_slot & w_empty;
    assign w_push    = i_enable & io_iq.i_iqdata_fp;
    assign w_ovf_evt = w_push & w_full & ~w_pop;
    iq_sync_fifo #(
        .W      (2*DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .i_clk   (i_fpga_clk),
        .i_rst_n (i_fpga_rst),
        .i_flush (~i_enable),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({io_iq.i_idata, io_iq.i_qdata}),
        .o_rdata (w_rdata),
        .o_level (w_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    always_comb begin
        w_next = !i_enable ? IDLE :
                 r_state == IDLE ? FILL :
                 r_state == FILL ? (w_level >= (ADDR_W+1)'(PRIME_LVL) ? RUN : FILL) :
                 r_state == RUN  ? (w_udf_evt ? FILL : RUN) : IDLE;
        w_pace_next = (r_state == RUN && w_next == RUN) ?
                      (r_pace == PACE_W'(OUT_INTERVAL-1) ? '0 : r_pace + PACE_W'(1)) : '0;
    end
    always_ff @(posedge i_fpga_clk or negedge i_fpga_rst) begin
        if (!i_fpga_rst) begin
            r_state   <= IDLE;
            r_pace    <= '0;
            r_running <= 1'b0;
            r_strobe  <= 1'b0;
            r_idata   <= '0;
            r_qdata   <= '0;
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_pace    <= w_pace_next;
            r_running <= w_next == RUN;
            r_strobe  <= w_pop;
            if (w_pop) {r_idata, r_qdata} <= w_rdata;
            r_ovf     <= w_ovf_evt | (r_ovf & ~i_clr_status);
            r_udf     <= w_udf_evt | (r_udf & ~i_clr_status);
        end
    end
    assign io_iq.o_iqdata_fp = r_strobe;
    assign io_iq.o_idata     = r_idata;
    assign io_iq.o_qdata     = r_qdata;
    assign o_level           = w_level;
    assign o_running         = r_running;
    assign o_ovf             = r_ovf;
    assign o_udf             = r_udf;
endmodule

// File: tb/tb_iq_rate_buffer.sv
// tb_iq_rate_buffer: directed vector table plus hand-written overflow/underflow/enable/reset sequences
module tb_iq_rate_buffer;
    typedef struct {
        logic        fp;
        logic [11:0] i;
        logic [11:0] q;
        logic        exp_fp;
        logic [11:0] exp_i;
        logic [11:0] exp_q;
        logic [4:0]  exp_lvl;
        logic        exp_run;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic clr = 1'b0;
    logic [4:0] level;
    logic running, ovf, udf;
    int n_chk  = 0;
    int n_fail = 0;
    int s_idx  = 0;
    vec_t tbl [57];
    int seq [$] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 22, 26, 30, 'h101};
    iq_rate_buffer_if #(.DW(12)) iq ();
    iq_rate_buffer dut (
        .i_fpga_clk   (clk),
        .i_fpga_rst   (rst),
        .i_enable     (en),
        .i_clr_status (clr),
        .io_iq        (iq.slave),
        .o_level      (level),
        .o_running    (running),
        .o_ovf        (ovf),
        .o_udf        (udf)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask
    task automatic chk_zero(input string nm);
        chk({nm, " fp"}, 32'(iq.o_iqdata_fp), 0);
        chk({nm, " I"}, 32'(iq.o_idata), 0);
        chk({nm, " Q"}, 32'(iq.o_qdata), 0);
        chk({nm, " lvl"}, 32'(level), 0);
        chk({nm, " run"}, 32'(running), 0);
        chk({nm, " ovf"}, 32'(ovf), 0);
        chk({nm, " udf"}, 32'(udf), 0);
    endtask
    task automatic do_reset();
        en = 1'b0;
        clr = 1'b0;
        iq.i_iqdata_fp = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask
    task automatic drive(input logic fp, input logic [11:0] v);
        iq.i_iqdata_fp = fp;
        iq.i_idata = v;
        iq.i_qdata = 12'h800 + v;
    endtask
    task automatic run_table(input int last);
        for (int k = 0; k <= last; k++) begin
            en = 1'b1;
            iq.i_iqdata_fp = tbl[k].fp;
            iq.i_idata = tbl[k].i;
            iq.i_qdata = tbl[k].q;
            tick();
            chk($sformatf("tbl[%0d] fp", k), 32'(iq.o_iqdata_fp), 32'(tbl[k].exp_fp));
            chk($sformatf("tbl[%0d] I", k), 32'(iq.o_idata), 32'(tbl[k].exp_i));
            chk($sformatf("tbl[%0d] Q", k), 32'(iq.o_qdata), 32'(tbl[k].exp_q));
            chk($sformatf("tbl[%0d] lvl", k), 32'(level), 32'(tbl[k].exp_lvl));
            chk($sformatf("tbl[%0d] run", k), 32'(running), 32'(tbl[k].exp_run));
            chk($sformatf("tbl[%0d] ovf", k), 32'(ovf), 0);
            chk($sformatf("tbl[%0d] udf", k), 32'(udf), 0);
        end
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        // startup cadence: one RX strobe every 4 clocks, RUN one cycle after level 8, pops every 4th cycle from cycle 30
        for (int k = 0; k < 57; k++) begin
            int n_push;
            int n_pop;
            n_push = k / 4 + 1;
            n_pop = k >= 30 ? (k - 30) / 4 + 1 : 0;
            tbl[k].fp = (k % 4) == 0;
            tbl[k].i = 12'(n_push);
            tbl[k].q = 12'(32'h800 + n_push);
            tbl[k].exp_fp = k >= 30 && ((k - 30) % 4) == 0;
            tbl[k].exp_i = 12'(n_pop);
            tbl[k].exp_q = n_pop > 0 ? 12'(32'h800 + n_pop) : 12'h000;
            tbl[k].exp_lvl = 5'(n_push - n_pop);
            tbl[k].exp_run = k >= 29;
        end
        drive(1'b0, 12'h000);
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b1;
        run_table(40);
        #2 rst = 1'b0;
        #1 chk_zero("async reset");
        tick();
        rst = 1'b1;
        run_table(56);
        en = 1'b0;
        drive(1'b0, 12'h000);
        tick();
        chk("endrop lvl", 32'(level), 0);
        chk("endrop run", 32'(running), 0);
        chk("endrop fp", 32'(iq.o_iqdata_fp), 0);
        chk("endrop I", 32'(iq.o_idata), 32'h007);
        chk("endrop Q", 32'(iq.o_qdata), 32'h807);
        tick();
        chk("endrop fp2", 32'(iq.o_iqdata_fp), 0);
        en = 1'b1;
        for (int m = 0; m < 8; m++) begin
            drive(1'b1, 12'(32'h201 + m));
            tick();
            if (m == 0) chk("reprime lvl1", 32'(level), 1);
        end
        chk("reprime lvl8", 32'(level), 8);
        chk("reprime run0", 32'(running), 0);
        drive(1'b0, 12'h000);
        tick();
        chk("reprime run1", 32'(running), 1);
        tick();
        chk("reprime fp", 32'(iq.o_iqdata_fp), 1);
        chk("reprime I", 32'(iq.o_idata), 32'h201);
        do_reset();
        for (int k = 0; k <= 108; k++) begin
            en = 1'b1;
            clr = k == 98;
            drive(k < 30 || (k >= 98 && k <= 105), k < 30 ? 12'(k + 1) : 12'(32'h100 + k - 97));
            tick();
            if (iq.o_iqdata_fp) begin
                if (s_idx < seq.size()) begin
                    chk($sformatf("ovf strobe%0d I", s_idx), 32'(iq.o_idata), 32'(seq[s_idx]));
                    chk($sformatf("ovf strobe%0d Q", s_idx), 32'(iq.o_qdata), 32'(12'(32'h800 + seq[s_idx])));
                end
                s_idx++;
            end
            if (k == 17) chk("ovf lvl15", 32'(level), 15);
            if (k == 18) begin
                chk("ovf lvl16", 32'(level), 16);
                chk("ovf pre", 32'(ovf), 0);
            end
            if (k == 19) begin
                chk("ovf sat", 32'(level), 16);
                chk("ovf set", 32'(ovf), 1);
            end
            if (k == 29) chk("ovf lvl end", 32'(level), 16);
            if (k == 96) begin
                chk("udf run", 32'(running), 1);
                chk("udf pre", 32'(udf), 0);
            end
            if (k == 97) begin
                chk("udf set", 32'(udf), 1);
                chk("udf run0", 32'(running), 0);
                chk("udf nostrobe", 32'(iq.o_iqdata_fp), 0);
            end
            if (k == 98) begin
                chk("clr ovf", 32'(ovf), 0);
                chk("clr udf", 32'(udf), 0);
                chk("refill lvl1", 32'(level), 1);
            end
            if (k == 105) begin
                chk("refill lvl8", 32'(level), 8);
                chk("refill run0", 32'(running), 0);
            end
            if (k == 106) chk("refill run1", 32'(running), 1);
        end
        chk("ovf strobe count", 32'(s_idx), 23);
        do_reset();
        for (int k = 0; k <= 23; k++) begin
            en = 1'b1;
            clr = k >= 22;
            drive(k <= 18 || k == 21 || k == 22, k <= 18 ? 12'(k + 1) : (k == 21 ? 12'h3AA : 12'h3BB));
            tick();
            if (k == 19) begin
                chk("full lvl", 32'(level), 16);
                chk("full ovf", 32'(ovf), 0);
            end
            if (k == 20) chk("full ovf2", 32'(ovf), 0);
            if (k == 21) begin
                chk("pushpop lvl", 32'(level), 16);
                chk("pushpop ovf", 32'(ovf), 0);
                chk("pushpop fp", 32'(iq.o_iqdata_fp), 1);
                chk("pushpop I", 32'(iq.o_idata), 4);
            end
            if (k == 22) begin
                chk("setwins ovf", 32'(ovf), 1);
                chk("setwins lvl", 32'(level), 16);
            end
            if (k == 23) chk("clr ovf2", 32'(ovf), 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
